prio_encoder_arb: RTL and testbench
===================================

# prio_encoder_arb

Parametrised, registered successor to the 4-input combinational priority encoder. It takes N request lines and produces a registered grant with both an index and a one-hot form. The grant is held under a valid/ready handshake. A run-time mode input selects between fixed priority (highest index wins) and round-robin priority, where a rotating pointer advances after each accepted grant. The block sits between request sources and a single shared consumer as the arbitration/encode stage.

## Interface
- N, default 8: number of request lines; legal range 1..64; values that are not a power of two are supported.
- IDX_W, default 3: grant index width; must equal max(1, ceil(log2(N))).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  N  request lines; bit i is request from source i; level-sensitive, sampled on load edges only.
- mode  input  1  0 = fixed priority (highest set index wins); 1 = round-robin; sampled on load edges only.
- grant_ready  input  1  consumer accepts the current grant.
- grant_valid  output  1  a grant is presented.
- grant_idx  output  IDX_W  index of the granted request.
- grant_onehot  output  N  one-hot of grant_idx; all zero when grant_valid=0.
- any_req  output  1  registered OR of req, updated every cycle, independent of the handshake.

## Operation
- Transfer occurs on an edge where grant_valid=1 and grant_ready=1.
- Load condition at an edge: grant_valid=0 OR grant_ready=1.
  - On a load edge: grant_valid <= |req; grant_idx/grant_onehot <= selection(req, mode, ptr_eff).
  - If req=0: grant_valid <= 0, grant_idx <= 0, grant_onehot <= 0.
- Hold: when grant_valid=1 and grant_ready=0, grant_idx and grant_onehot stay stable.
  - This holds even if the granted req bit drops or mode changes. The grant is never revoked.
- Fixed selection (mode=0): highest index i with req[i]=1.
- Round-robin selection (mode=1): first i with req[i]=1, scanning upward from ptr_eff through N-1, then wrapping to 0..ptr_eff-1.
- Rotating pointer ptr, width IDX_W, range 0..N-1.
  - On a transfer with mode=1: ptr <= (grant_idx == N-1) ? 0 : grant_idx+1.
  - With mode=0, ptr holds its value. A return to mode=1 resumes from the retained ptr.
- ptr_eff: equals the next ptr value on a transfer edge with mode=1, otherwise the current ptr. A back-to-back load therefore never re-grants the same source while other requests are pending.
- Never both: grant_valid=0 with a nonzero grant_onehot.
- N=1: grant_idx is fixed at 0, ptr stays 0, and mode has no effect.

## Timing
- Reset (rst=1 at an edge): grant_valid=0, grant_idx=0, grant_onehot=0, any_req=0, ptr=0.
  - Reset overrides any held grant or handshake in progress, so a held grant is dropped without a transfer.
  - The first load is on the first edge with rst=0.
- Latency: req sampled at edge t appears on the grant outputs after edge t (1 cycle), provided edge t is a load edge.
- any_req: 1 cycle after req, every cycle.
- Throughput: one grant per cycle when grant_ready is held at 1.
- grant_ready may be asserted while grant_valid=0; it has no effect except making the edge a load edge.
- No combinational path from any input to any output.

## Test plan
- Reset/idle: rst high 2 cycles with req=8'hFF → all outputs 0, ptr=0. Release rst, then req=0 → grant_valid stays 0 and grant_onehot=0.
- Fixed priority: mode=0, req=8'b0101_0010, grant_ready=1 → next cycle grant_idx=6, grant_onehot=8'h40. Then req=8'h01 → grant_idx=0.
- Round-robin rotation and wrap: mode=1, req=8'b1000_1001, grant_ready=1 held → grants 0, 3, 7, 0, 3 on consecutive cycles. ptr wraps 7→0.
- Hold under backpressure: grant_idx=3 valid, grant_ready=0 for 4 cycles while req changes to 8'h80 and mode toggles → outputs remain idx=3, onehot=8'h08. Then grant_ready=1 → transfer; the next grant is idx=7.
- Non-power-of-two wrap: N=5, IDX_W=3, mode=1, req=5'b10001, grant_ready=1 → grants 0, 4, 0, 4. ptr never exceeds 4.
- Reset mid-operation: grant held (idx=5, ready=0, ptr=5), assert rst one cycle → all outputs 0, ptr=0. After release with mode=1, req=8'hFF → grant_idx=0.

Source files
------------

// File: rtl/prio_encoder_arb_if.sv
// Request/grant bundle for prio_encoder_arb: the request side drives req/mode/grant_ready,
// the arbiter drives the registered grant and any_req.
interface prio_encoder_arb_if #(
    parameter int N     = 8,
    parameter int IDX_W = 3
);
    logic [N-1:0]     req;
    logic             mode;
    logic             grant_ready;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [N-1:0]     grant_onehot;
    logic             any_req;

    // Handshake: a grant transfers on an edge with grant_valid=1 and grant_ready=1; while
    // grant_valid=1 and grant_ready=0 the grant is held stable and never revoked.
    modport master (
        output req, mode, grant_ready,
        input  grant_valid, grant_idx, grant_onehot, any_req
    );

    modport slave (
        input  req, mode, grant_ready,
        output grant_valid, grant_idx, grant_onehot, any_req
    );
endinterface

// File: rtl/prio_encoder_arb.sv
// Registered N-way priority encoder/arbiter: fixed (highest index wins) or round-robin
// selection, grant held under valid/ready, rotating pointer exposed on dbg_ptr.
module prio_encoder_arb #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    prio_encoder_arb_if.slave bus,
    output logic [IDX_W-1:0] dbg_ptr
);
    logic             valid_q;
    logic [IDX_W-1:0] idx_q;
    logic [N-1:0]     onehot_q;
    logic             any_q;
    logic [IDX_W-1:0] ptr_q;

    logic             load;
    logic             xfer;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] ptr_eff;
    logic [IDX_W-1:0] sel_idx;
    logic [N-1:0]     sel_onehot;
    logic [2*N-1:0]   req_dbl;
    logic [N-1:0]     req_rot;
    logic [IDX_W:0]   rr_sum;
    logic             rr_found;

    assign load    = !valid_q || bus.grant_ready;
    assign xfer    = valid_q && bus.grant_ready;
    assign ptr_nxt = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);
    // Using the post-transfer pointer on a back-to-back load keeps the just-served source last in line.
    assign ptr_eff = (xfer && bus.mode) ? ptr_nxt : ptr_q;

    // req_rot[k] is the request of source (ptr_eff + k) mod N.
    assign req_dbl = {bus.req, bus.req};
    assign req_rot = N'(req_dbl >> ptr_eff);

    always_comb begin
        sel_idx  = '0;
        rr_sum   = '0;
        rr_found = 1'b0;
        if (!bus.mode) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req[i]) sel_idx = IDX_W'(i);
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!rr_found && req_rot[k]) begin
                    rr_found = 1'b1;
                    rr_sum   = {1'b0, ptr_eff} + (IDX_W + 1)'(k);
                end
            end
            if (rr_sum >= (IDX_W + 1)'(N)) rr_sum = rr_sum - (IDX_W + 1)'(N);
            sel_idx = rr_sum[IDX_W-1:0];
        end
        sel_onehot = N'(1) << sel_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
            any_q    <= 1'b0;
            ptr_q    <= '0;
        end else begin
            any_q <= |bus.req;
            if (load) begin
                valid_q  <= |bus.req;
                idx_q    <= (|bus.req) ? sel_idx : '0;
                onehot_q <= (|bus.req) ? sel_onehot : '0;
            end
            if (xfer && bus.mode) ptr_q <= ptr_nxt;
        end
    end

    assign bus.grant_valid  = valid_q;
    assign bus.grant_idx    = idx_q;
    assign bus.grant_onehot = onehot_q;
    assign bus.any_req      = any_q;
    assign dbg_ptr          = ptr_q;
endmodule

// File: tb/tb_prio_encoder_arb.sv
// Bench for prio_encoder_arb: an N=8 and an N=5 instance, expected grants queued when
// stimulus is driven and compared one cycle later.
module tb_prio_encoder_arb;
    localparam int N     = 8;
    localparam int N5    = 5;
    localparam int IDX_W = 3;
    localparam int W     = 1 + IDX_W + N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prio_encoder_arb_if #(.N(N),  .IDX_W(IDX_W)) bus8 ();
    prio_encoder_arb_if #(.N(N5), .IDX_W(IDX_W)) bus5 ();
    logic [IDX_W-1:0] ptr8;
    logic [IDX_W-1:0] ptr5;

    prio_encoder_arb #(.N(N), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .bus(bus8.slave), .dbg_ptr(ptr8)
    );
    prio_encoder_arb #(.N(N5), .IDX_W(IDX_W)) dut5 (
        .clk(clk), .rst(rst), .bus(bus5.slave), .dbg_ptr(ptr5)
    );

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp5_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push8(input logic v, input int idx);
        logic [N-1:0] oh;
        oh = v ? (N'(1) << idx) : '0;
        exp_q.push_back({v, IDX_W'(idx), oh});
    endtask

    task automatic push5(input logic v, input int idx);
        logic [N-1:0] oh;
        oh = v ? (N'(1) << idx) : '0;
        exp5_q.push_back({v, IDX_W'(idx), oh});
    endtask

    // One clock, then compare everything queued for this edge.
    task automatic step();
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("valid8",  64'(bus8.grant_valid),  64'(e[W-1]));
            check("idx8",    64'(bus8.grant_idx),    64'(e[N+IDX_W-1:N]));
            check("onehot8", 64'(bus8.grant_onehot), 64'(e[N-1:0]));
        end
        while (exp5_q.size() > 0) begin
            e = exp5_q.pop_front();
            check("valid5",  64'(bus5.grant_valid),  64'(e[W-1]));
            check("idx5",    64'(bus5.grant_idx),    64'(e[N+IDX_W-1:N]));
            check("onehot5", 64'(bus5.grant_onehot), 64'(e[N-1:0]));
        end
    endtask

    int rr_idx[5]  = '{0, 3, 7, 0, 3};
    int rr_ptr[5]  = '{0, 1, 4, 0, 1};
    int n5_idx[4]  = '{0, 4, 0, 4};
    int n5_ptr[4]  = '{0, 1, 0, 1};

    initial begin
        logic [N-1:0] r;
        int hi;

        rst = 1'b1;
        bus8.req = 8'hFF; bus8.mode = 1'b0; bus8.grant_ready = 1'b1;
        bus5.req = 5'h1F; bus5.mode = 1'b0; bus5.grant_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push8(1'b0, 0); push5(1'b0, 0);
            step();
        end
        check("any_req_rst", 64'(bus8.any_req), 64'(0));
        check("ptr_rst", 64'(ptr8), 64'(0));
        check("ptr5_rst", 64'(ptr5), 64'(0));

        rst = 1'b0;
        bus8.req = '0; bus5.req = '0;
        push8(1'b0, 0); push5(1'b0, 0);
        step();
        check("any_req_idle", 64'(bus8.any_req), 64'(0));

        bus8.mode = 1'b0; bus8.req = 8'b0101_0010;
        push8(1'b1, 6); step();
        check("any_req_set", 64'(bus8.any_req), 64'(1));
        bus8.req = 8'h01;
        push8(1'b1, 0); step();
        check("ptr_fixed", 64'(ptr8), 64'(0));
        bus8.req = '0;
        push8(1'b0, 0); step();

        bus8.mode = 1'b1; bus8.req = 8'b1000_1001;
        for (int i = 0; i < 5; i++) begin
            push8(1'b1, rr_idx[i]); step();
            check("ptr_rr", 64'(ptr8), 64'(rr_ptr[i]));
        end

        bus8.grant_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus8.req = 8'h80; bus8.mode = i[0];
            push8(1'b1, 3); step();
            check("ptr_hold", 64'(ptr8), 64'(1));
        end
        bus8.grant_ready = 1'b1; bus8.mode = 1'b1;
        push8(1'b1, 7); step();
        check("ptr_after_hold", 64'(ptr8), 64'(4));

        bus8.req = 8'h10; push8(1'b1, 4); step();
        check("ptr_pre5a", 64'(ptr8), 64'(0));
        bus8.req = 8'h20; push8(1'b1, 5); step();
        check("ptr_pre5b", 64'(ptr8), 64'(5));
        bus8.grant_ready = 1'b0; push8(1'b1, 5); step();
        check("ptr_held5", 64'(ptr8), 64'(5));

        rst = 1'b1;
        push8(1'b0, 0); push5(1'b0, 0); step();
        check("ptr_midrst", 64'(ptr8), 64'(0));
        check("any_req_midrst", 64'(bus8.any_req), 64'(0));
        rst = 1'b0;
        bus8.mode = 1'b1; bus8.req = 8'hFF; bus8.grant_ready = 1'b1;
        push8(1'b1, 0); step();
        check("ptr_post_rst", 64'(ptr8), 64'(0));

        bus8.mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r = N'($urandom_range(0, 255));
            hi = 0;
            for (int b = 0; b < N; b++) if (r[b]) hi = b;
            bus8.req = r;
            push8(|r, hi); step();
            check("any_req_rand", 64'(bus8.any_req), 64'(|r));
        end

        bus8.req = '0;
        bus5.mode = 1'b1; bus5.req = 5'b10001; bus5.grant_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push5(1'b1, n5_idx[i]); step();
            check("ptr5_rr", 64'(ptr5), 64'(n5_ptr[i]));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
